// File: rtl/add_pipe_8b.sv
// add_pipe_8b: two-stage pipelined 8-bit adder with valid/ready handshake.
// Stage 1 adds the low nibble; stage 2 adds the high nibble with the
// registered nibble carry and drives sum/cout straight from its registers.
module add_pipe_8b (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] sum,
   output logic       cout
);

   localparam int unsigned W  = 8;
   localparam int unsigned HW = W / 2;

   // 4-bit ripple-carry slice; returns {carry_out, sum[3:0]}
   function automatic logic [HW:0] ripple4(
      input logic [HW-1:0] x,
      input logic [HW-1:0] y,
      input logic          ci
   );
      logic          c;
      logic [HW-1:0] s;
      c = ci;
      s = '0;
      for (int i = 0; i < int'(HW); i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   // Stage-1 state
   logic          v1;
   logic [HW-1:0] s1_lo;
   logic          s1_c4;
   logic [HW-1:0] s1_a_hi;
   logic [HW-1:0] s1_b_hi;

   // Stage-2 state (sum/cout are the data registers themselves)
   logic          v2;

   // Handshake / load enables
   logic          ld1;
   logic          ld2;
   logic [HW:0]   lo_res;
   logic [HW:0]   hi_res;

   // Load enables: a stage advances when empty or when its consumer advances
   always_comb begin
      ld2      = ~v2 | out_ready;
      ld1      = ~v1 | ld2;
      in_ready = ~v1 | ~v2 | out_ready;
   end

   // Nibble adders for both stages
   always_comb begin
      lo_res = ripple4(a[HW-1:0], b[HW-1:0], cin);
      hi_res = ripple4(s1_a_hi, s1_b_hi, s1_c4);
   end

   // Stage 1: low nibble result, nibble carry and the high operand nibbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         s1_lo   <= '0;
         s1_c4   <= 1'b0;
         s1_a_hi <= '0;
         s1_b_hi <= '0;
      end else if (ld1) begin
         v1      <= in_valid & in_ready;
         s1_lo   <= lo_res[HW-1:0];
         s1_c4   <= lo_res[HW];
         s1_a_hi <= a[W-1:HW];
         s1_b_hi <= b[W-1:HW];
      end
   end

   // Stage 2: high nibble result joined with the low nibble; holds while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
      end else if (ld2) begin
         v2   <= v1;
         sum  <= {hi_res[HW-1:0], s1_lo};
         cout <= hi_res[HW];
      end
   end

   assign out_valid = v2;

endmodule

// File: tb/tb_add_pipe_8b.sv
// tb_add_pipe_8b: directed and randomized handshake bench for add_pipe_8b.
module tb_add_pipe_8b;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;

   int checks   = 0;
   int failures = 0;

   logic [8:0] exp_q[$];

   add_pipe_8b dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it on mismatch
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic c);
      in_valid = v;
      a        = x;
      b        = y;
      cin      = c;
      #1;
   endtask

   // Output monitor: every output transfer must match the oldest expected result
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'({cout, sum}), 32'h1ff0);
         end else begin
            check("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
         end
      end
   end

   logic [7:0] va[4];
   logic [7:0] vb[4];
   logic [8:0] ve[4];
   int         idx;
   int         sent;
   int         budget;

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      repeat (2) tick();

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_sum",       32'(sum),       32'h00);
      check("rst_cout",      32'(cout),      32'h0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'h1);

      // FF+01: result visible two edges after presentation
      drive(1'b1, 8'hFF, 8'h01, 1'b0);
      check("lat_in_ready", 32'(in_ready), 32'h1);
      exp_q.push_back(9'h100);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      check("lat_early_valid", 32'(out_valid), 32'h0);
      tick();
      check("lat_valid", 32'(out_valid), 32'h1);
      check("lat_value", 32'({cout, sum}), 32'h100);
      tick();

      // Nibble carry and all-ones with carry-in
      drive(1'b1, 8'h0F, 8'h01, 1'b0);
      exp_q.push_back(9'h010);
      tick();
      drive(1'b1, 8'hFF, 8'hFF, 1'b1);
      exp_q.push_back(9'h1FF);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      check("nib_value", 32'({cout, sum}), 32'h010);
      tick();
      check("ones_value", 32'({cout, sum}), 32'h1FF);
      tick();

      // Back-to-back stream at full throughput
      va = '{8'h01, 8'h10, 8'h80, 8'h00};
      vb = '{8'h02, 8'h20, 8'h80, 8'h00};
      ve = '{9'h003, 9'h030, 9'h100, 9'h000};
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            drive(1'b1, va[i], vb[i], 1'b0);
            exp_q.push_back(ve[i]);
         end else begin
            drive(1'b0, 8'h00, 8'h00, 1'b0);
         end
         check("b2b_in_ready", 32'(in_ready), 32'h1);
         tick();
         if (i >= 1) begin
            check("b2b_valid", 32'(out_valid), 32'h1);
            check("b2b_value", 32'({cout, sum}), 32'(ve[i-1]));
         end
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      tick();

      // Backpressure: fill, stall, then drain in order
      va = '{8'h11, 8'h40, 8'h7F, 8'hC0};
      vb = '{8'h22, 8'h50, 8'h01, 8'hC0};
      ve = '{9'h033, 9'h090, 9'h080, 9'h180};
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, va[idx], vb[idx], 1'b0);
         if (c >= 2) check("full_in_ready", 32'(in_ready), 32'h0);
         if (in_ready) begin
            exp_q.push_back(ve[idx]);
            idx++;
         end
         tick();
         if (c >= 1) begin
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_hold",  32'({cout, sum}), 32'h033);
         end
      end
      check("stall_accepts", 32'(idx), 32'd2);
      out_ready = 1'b1;
      budget = 0;
      while (idx < 4 && budget < 20) begin
         drive(1'b1, va[idx], vb[idx], 1'b0);
         if (in_ready) begin
            exp_q.push_back(ve[idx]);
            idx++;
         end
         tick();
         budget++;
      end
      check("refill_done", 32'(idx), 32'd4);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      repeat (4) tick();
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-operation discards both in-flight results
      out_ready = 1'b0;
      drive(1'b1, 8'h12, 8'h34, 1'b0);
      tick();
      drive(1'b1, 8'h56, 8'h78, 1'b1);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      check("mid_rst_value", 32'({cout, sum}), 32'h000);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("post_rst_quiet", 32'(out_valid), 32'h0);
      end
      drive(1'b1, 8'h5A, 8'h33, 1'b1);
      exp_q.push_back(9'h08E);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      check("post_rst_valid", 32'(out_valid), 32'h1);
      check("post_rst_value", 32'({cout, sum}), 32'h08E);
      tick();

      // Random valid/ready toggling against a+b+cin
      sent = 0;
      budget = 0;
      while (sent < 10000 && budget < 60000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
         if (in_valid && in_ready) begin
            exp_q.push_back(9'(a) + 9'(b) + 9'(cin));
            sent++;
         end
         tick();
         budget++;
      end
      check("rand_sent", 32'(sent), 32'd10000);
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      repeat (5) tick();
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
